instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute/writeback sequencer for the 2-bit-opcode processor core. It owns the program counter and instruction register, and runs a request/acknowledge handshake to instruction memory. It drives the datapath steering and register-file write enable one phase at a time. Unused selects are never driven to X. It sits between instruction memory and the register file/ALU datapath.

---
 rtl/proc_pkg.sv | 24 ++
 rtl/steer_decode.sv | 27 ++
 rtl/instr_sequencer.sv | 153 +++++++++++++++
 tb/tb_instr_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types for the 2-bit-opcode processor core.
// Opcode constants, sequencer state encoding and steering bundle.
package proc_pkg;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_NOP = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK
    } seq_state_e;

    typedef struct packed {
        logic ReadRegAddrSelect;
        logic AluSelect;
        logic WriteRegDataSelect;
    } steer_t;

endpackage

// File: rtl/steer_decode.sv
// Opcode to datapath steering map.
// Purely combinational; every opcode yields a defined value.
module steer_decode
    import proc_pkg::*;
(
    input  logic [1:0] opcode_i,
    output steer_t     steer_o
);

    // mov and sll steer the datapath; nop and j leave it idle
    always_comb begin
        steer_o = '0;
        unique case (1'b1)
            (opcode_i == OP_MOV): begin
                steer_o.ReadRegAddrSelect  = 1'b1;
            end
            (opcode_i == OP_SLL): begin
                steer_o.AluSelect          = 1'b1;
                steer_o.WriteRegDataSelect = 1'b1;
            end
            default: begin
                steer_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer.
// Owns PC and IR and handshakes with instruction memory.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int INSTR_WIDTH  = 8,
    parameter int PC_WIDTH     = 6,
    parameter int RETIRE_WIDTH = 16
) (
    input  logic                    Clock,
    input  logic                    ResetN,
    input  logic                    Run,
    output logic                    InstrReq,
    output logic [PC_WIDTH-1:0]     InstrAddr,
    input  logic                    InstrAck,
    input  logic [INSTR_WIDTH-1:0]  InstrData,
    output logic [INSTR_WIDTH-1:0]  Instr,
    output logic                    IsJump,
    output logic                    ReadRegAddrSelect,
    output logic                    AluSelect,
    output logic                    WriteRegDataSelect,
    output logic                    WriteEnable,
    output logic                    Busy,
    output logic [RETIRE_WIDTH-1:0] RetiredCount
);

    seq_state_e              state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    steer_t                  steer_q, steer_d;
    steer_t                  steer_dec;
    logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
    logic [1:0]              opcode;
    logic                    is_long;
    logic                    retire;
    logic                    take_jump;

    assign opcode  = instr_q[INSTR_WIDTH-1:INSTR_WIDTH-2];
    assign is_long = (opcode == OP_MOV) || (opcode == OP_SLL);

    steer_decode u_steer_decode (
        .opcode_i (opcode),
        .steer_o  (steer_dec)
    );

    // State register
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Run only matters in IDLE and at retirement
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (InstrAck) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_long) state_d = ST_WRITEBACK;
                else         state_d = Run ? ST_FETCH : ST_IDLE;
            end
            ST_WRITEBACK: begin
                state_d = Run ? ST_FETCH : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-state control outputs and retirement strobe
    always_comb begin
        InstrReq    = 1'b0;
        WriteEnable = 1'b0;
        IsJump      = 1'b0;
        Busy        = 1'b1;
        retire      = 1'b0;
        take_jump   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                Busy = 1'b0;
            end
            ST_FETCH: begin
                InstrReq = 1'b1;
            end
            ST_EXECUTE: begin
                IsJump    = (opcode == OP_J);
                take_jump = (opcode == OP_J);
                retire    = !is_long;
            end
            ST_WRITEBACK: begin
                WriteEnable = 1'b1;
                retire      = 1'b1;
            end
            default: begin
                Busy = 1'b1;
            end
        endcase
    end

    // Next values for PC, IR, steering and retire counter
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        steer_d   = steer_q;
        retired_d = retired_q;
        if (state_q == ST_FETCH && InstrAck) begin
            instr_d = InstrData;
        end
        if (state_q == ST_DECODE) begin
            steer_d = steer_dec;
        end
        if (retire) begin
            steer_d   = '0;
            retired_d = retired_q + RETIRE_WIDTH'(1);
            if (take_jump) pc_d = instr_q[PC_WIDTH-1:0];
            else           pc_d = pc_q + PC_WIDTH'(1);
        end
    end

    // Architectural registers
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            pc_q      <= '0;
            instr_q   <= '0;
            steer_q   <= '0;
            retired_q <= '0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            steer_q   <= steer_d;
            retired_q <= retired_d;
        end
    end

    assign InstrAddr          = pc_q;
    assign Instr              = instr_q;
    assign ReadRegAddrSelect  = steer_q.ReadRegAddrSelect;
    assign AluSelect          = steer_q.AluSelect;
    assign WriteRegDataSelect = steer_q.WriteRegDataSelect;
    assign RetiredCount       = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer.
// Instruction-level reference model with random memory latency.
module tb_instr_sequencer;

    logic        Clock;
    logic        ResetN;
    logic        Run;
    logic        InstrReq;
    logic [5:0]  InstrAddr;
    logic        InstrAck;
    logic [7:0]  InstrData;
    logic [7:0]  Instr;
    logic        IsJump;
    logic        ReadRegAddrSelect;
    logic        AluSelect;
    logic        WriteRegDataSelect;
    logic        WriteEnable;
    logic        Busy;
    logic [15:0] RetiredCount;

    logic [6:0]  ctl;
    logic [5:0]  m_pc;
    logic [15:0] m_ret;
    int          checks;
    int          errors;

    instr_sequencer #(
        .INSTR_WIDTH  (8),
        .PC_WIDTH     (6),
        .RETIRE_WIDTH (16)
    ) dut (
        .Clock              (Clock),
        .ResetN             (ResetN),
        .Run                (Run),
        .InstrReq           (InstrReq),
        .InstrAddr          (InstrAddr),
        .InstrAck           (InstrAck),
        .InstrData          (InstrData),
        .Instr              (Instr),
        .IsJump             (IsJump),
        .ReadRegAddrSelect  (ReadRegAddrSelect),
        .AluSelect          (AluSelect),
        .WriteRegDataSelect (WriteRegDataSelect),
        .WriteEnable        (WriteEnable),
        .Busy               (Busy),
        .RetiredCount       (RetiredCount)
    );

    assign ctl = {InstrReq, WriteEnable, IsJump, ReadRegAddrSelect,
                  AluSelect, WriteRegDataSelect, Busy};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Steering triple {RdSel, AluSel, WrSel} expected for an opcode
    function automatic logic [2:0] sel_of(input logic [1:0] op);
        case (op)
            2'b00:   return 3'b100;
            2'b01:   return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    task automatic do_reset();
        ResetN    = 1'b0;
        Run       = 1'b0;
        InstrAck  = 1'b0;
        InstrData = '0;
        @(negedge Clock);
        ResetN = 1'b1;
        m_pc   = '0;
        m_ret  = '0;
    endtask

    // Entered at a FETCH-cycle negedge; leaves at the next boundary cycle
    task automatic exec_instr(input logic [7:0] data, input int dly,
                              input logic run_end, input string tag);
        logic [1:0] op;
        logic [2:0] sel;
        logic       lng;
        op  = data[7:6];
        sel = sel_of(op);
        lng = (op == 2'b00) || (op == 2'b01);
        for (int c = 0; c <= dly; c++) begin
            checks++;
            if ({ctl, InstrAddr} !== {7'b1000001, m_pc}) begin
                errors++;
                $display("FAIL %s fetch c%0d: got ctl=%b addr=%0d want ctl=%b addr=%0d",
                         tag, c, ctl, InstrAddr, 7'b1000001, m_pc);
            end
            Run       = 1'($urandom);
            InstrAck  = (c == dly);
            InstrData = (c == dly) ? data : 8'($urandom);
            @(negedge Clock);
        end
        InstrAck  = 1'($urandom);
        InstrData = 8'($urandom);
        Run       = 1'($urandom);
        checks++;
        if ({ctl, Instr} !== {7'b0000001, data}) begin
            errors++;
            $display("FAIL %s decode: got ctl=%b ir=%h want ctl=%b ir=%h",
                     tag, ctl, Instr, 7'b0000001, data);
        end
        @(negedge Clock);
        InstrAck  = 1'($urandom);
        InstrData = 8'($urandom);
        Run       = lng ? 1'($urandom) : run_end;
        checks++;
        if (ctl !== {2'b00, op == 2'b11, sel, 1'b1}) begin
            errors++;
            $display("FAIL %s execute: got ctl=%b want ctl=%b",
                     tag, ctl, {2'b00, op == 2'b11, sel, 1'b1});
        end
        if (lng) begin
            @(negedge Clock);
            Run = run_end;
            checks++;
            if ({ctl, Instr} !== {3'b010, sel, 1'b1, data}) begin
                errors++;
                $display("FAIL %s writeback: got ctl=%b ir=%h want ctl=%b ir=%h",
                         tag, ctl, Instr, {3'b010, sel, 1'b1}, data);
            end
        end
        m_pc  = (op == 2'b11) ? data[5:0] : m_pc + 6'd1;
        m_ret = m_ret + 16'd1;
        @(negedge Clock);
        InstrAck = 1'b0;
        checks++;
        if ({ctl, InstrAddr, RetiredCount} !==
            {run_end, 5'b00000, run_end, m_pc, m_ret}) begin
            errors++;
            $display("FAIL %s boundary: got ctl=%b pc=%0d ret=%0d want ctl=%b pc=%0d ret=%0d",
                     tag, ctl, InstrAddr, RetiredCount,
                     {run_end, 5'b00000, run_end}, m_pc, m_ret);
        end
    endtask

    task automatic test_reset();
        ResetN    = 1'b0;
        Run       = 1'b1;
        InstrAck  = 1'b1;
        InstrData = 8'hff;
        repeat (2) @(negedge Clock);
        checks++;
        if ({ctl, InstrAddr, Instr, RetiredCount} !== '0) begin
            errors++;
            $display("FAIL reset: got ctl=%b pc=%0d ir=%h ret=%0d want all zero",
                     ctl, InstrAddr, Instr, RetiredCount);
        end
        Run      = 1'b0;
        InstrAck = 1'b0;
        ResetN   = 1'b1;
        m_pc     = '0;
        m_ret    = '0;
        @(negedge Clock);
        checks++;
        if ({ctl, InstrAddr} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got ctl=%b pc=%0d want 0/0", ctl, InstrAddr);
        end
    endtask

    task automatic test_mov();
        Run = 1'b1;
        @(negedge Clock);
        exec_instr(8'b00_000011, 0, 1'b1, "mov");
    endtask

    task automatic test_sll_wait();
        do_reset();
        Run = 1'b1;
        @(negedge Clock);
        exec_instr(8'b01_000000, 3, 1'b1, "sll_wait");
    endtask

    task automatic test_jump_nop();
        do_reset();
        Run = 1'b1;
        @(negedge Clock);
        for (int i = 0; i < 5; i++) begin
            exec_instr({2'b10, 6'($urandom)}, 0, 1'b1, "nop_pre");
        end
        exec_instr(8'b11_101010, 1, 1'b1, "jump");
        exec_instr(8'b10_000000, 0, 1'b1, "nop");
    endtask

    task automatic test_wrap();
        exec_instr(8'b11_111111, 0, 1'b1, "jump63");
        exec_instr(8'b00_010101, 0, 1'b1, "wrap_mov");
    endtask

    task automatic test_run_drop();
        exec_instr(8'b00_001111, 1, 1'b0, "run_drop");
        repeat (3) begin
            @(negedge Clock);
            checks++;
            if ({ctl, InstrAddr} !== {7'b0000000, m_pc}) begin
                errors++;
                $display("FAIL idle_hold: got ctl=%b pc=%0d want ctl=0 pc=%0d",
                         ctl, InstrAddr, m_pc);
            end
        end
        Run = 1'b1;
        @(negedge Clock);
        exec_instr(8'b10_111111, 0, 1'b1, "resume");
    endtask

    task automatic test_reset_mid();
        InstrAck  = 1'b1;
        InstrData = 8'b00_000001;
        @(negedge Clock);
        InstrAck = 1'b0;
        @(negedge Clock);
        #2;
        ResetN = 1'b0;
        #1;
        checks++;
        if ({ctl, InstrAddr, Instr, RetiredCount} !== '0) begin
            errors++;
            $display("FAIL reset_async: got ctl=%b pc=%0d ir=%h ret=%0d want all zero",
                     ctl, InstrAddr, Instr, RetiredCount);
        end
        @(negedge Clock);
        checks++;
        if ({ctl, InstrAddr, RetiredCount} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got ctl=%b pc=%0d ret=%0d want all zero",
                     ctl, InstrAddr, RetiredCount);
        end
        Run    = 1'b0;
        ResetN = 1'b1;
        m_pc   = '0;
        m_ret  = '0;
        @(negedge Clock);
        checks++;
        if ({ctl, InstrAddr, RetiredCount} !== '0) begin
            errors++;
            $display("FAIL reset_release: got ctl=%b pc=%0d ret=%0d want all zero",
                     ctl, InstrAddr, RetiredCount);
        end
    endtask

    task automatic test_random();
        logic re;
        Run = 1'b1;
        @(negedge Clock);
        for (int i = 0; i < 60; i++) begin
            re = ($urandom_range(0, 3) != 0);
            exec_instr(8'($urandom), int'($urandom_range(0, 3)), re, "random");
            if (!re) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge Clock);
                    checks++;
                    if ({ctl, InstrAddr} !== {7'b0000000, m_pc}) begin
                        errors++;
                        $display("FAIL random_idle: got ctl=%b pc=%0d want ctl=0 pc=%0d",
                                 ctl, InstrAddr, m_pc);
                    end
                end
                Run = 1'b1;
                @(negedge Clock);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ResetN    = 1'b0;
        Run       = 1'b0;
        InstrAck  = 1'b0;
        InstrData = '0;
        m_pc      = '0;
        m_ret     = '0;
        test_reset();
        test_mov();
        test_sll_wait();
        test_jump_nop();
        test_wrap();
        test_run_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
